mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 14: word-address width of the shared RAM.
REQ-002 Parameter STARVE_MAX, default 3: maximum consecutive cycles a pending fetch loses to data.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 i_req  input  1  fetch request, held until i_gnt.
REQ-006 i_addr  input  32  fetch byte address; bits [ADDR_BITS+1:2] used.
REQ-007 i_gnt  output  1  fetch accepted this cycle.
REQ-008 i_rvalid  output  1  i_rdata valid.
REQ-009 i_rdata  output  32  instruction word.
REQ-010 d_req  input  1  data request, held until d_gnt.
REQ-011 d_addr  input  32  data byte address; bits [ADDR_BITS+1:2] used.
REQ-012 d_wmask  input  4  byte write mask; zero = load, nonzero = store.
REQ-013 d_wdata  input  32  store data, already lane-aligned.
REQ-014 d_gnt  output  1  data accepted this cycle.
REQ-015 d_rvalid  output  1  d_rdata valid (loads only).
REQ-016 d_rdata  output  32  load word.
REQ-017 ram_en  output  1  RAM access this cycle.
REQ-018 ram_addr  output  ADDR_BITS  RAM word address.
REQ-019 ram_wmask  output  4  RAM byte write enables.
REQ-020 ram_wdata  output  32  RAM write data.
REQ-021 ram_rdata  input  32  RAM read word, valid one cycle after ram_en with zero mask.
REQ-022 conflict_cnt  output  32  count of cycles with i_req and d_req both high.

Function
REQ-023 Grant is combinational from requests and arbiter state; at most one of i_gnt, d_gnt high per cycle.
REQ-024 Single request: that requester is granted the same cycle.
REQ-025 Both requesting: d_gnt wins unless starve_cnt == STARVE_MAX, then i_gnt wins.
REQ-026 starve_cnt (width clog2(STARVE_MAX+1)) increments on each cycle i_req is high without i_gnt; clears on i_gnt or when i_req is low; saturates at STARVE_MAX.
REQ-027 ram_en = i_gnt | d_gnt; ram_addr, ram_wmask and ram_wdata come from the granted requester; ram_wmask = 0 on fetch grants.
REQ-028 Response owner FSM states: IDLE, RESP_I, RESP_D; next state is RESP_I on i_gnt, RESP_D on d_gnt with d_wmask == 0, otherwise IDLE.
REQ-029 In RESP_I: i_rvalid = 1 and i_rdata = ram_rdata. In RESP_D: d_rvalid = 1 and d_rdata = ram_rdata. In IDLE: both rvalid are 0.
REQ-030 Load latency is exactly 1 cycle from grant to rvalid; back-to-back grants are allowed (one access per cycle, full throughput).
REQ-031 Stores produce d_gnt only; no d_rvalid follows.
REQ-032 i_rdata and d_rdata are 0 when the corresponding rvalid is low.
REQ-033 conflict_cnt wraps modulo 2^32.
REQ-034 A request dropped before its grant is legal and leaves no state other than starve_cnt clearing.

Reset
REQ-035 While resetn is low: FSM = IDLE, starve_cnt = 0, conflict_cnt = 0, and all gnt/rvalid/ram_en/ram_wmask outputs = 0, with requests ignored.
REQ-036 Reset asserted mid-access discards the in-flight response; no rvalid appears after reset release until a new grant.

Structure
REQ-037 State encoding (IDLE=2'd0, RESP_I=2'd1, RESP_D=2'd2) and the default STARVE_MAX belong in the shared core package.
REQ-038 Grant priority logic is one sub-module, arb_prio, combinational, with starve_cnt as input; the FSM and counters sit in mem_arbiter.

Verification
REQ-039 Fetch-only: i_req with i_addr=0x10 and RAM word 4 = 0x00000013 -> i_gnt at cycle 0, i_rvalid at cycle 1 with i_rdata=0x00000013, d_rvalid=0.
REQ-040 Collision: i_req and d_req (load 0x20) held continuously, STARVE_MAX=3 -> grant pattern D,D,D,I repeating; conflict_cnt=8 after 8 cycles.
REQ-041 Store then load: d_wmask=4'b0010 with d_wdata=0x0000AB00 at 0x40 (old word 0x11223344), then a load from 0x40 -> d_rdata=0x1122AB44 and no rvalid for the store.
REQ-042 Back-to-back: alternating I/D loads each cycle -> rvalid on every cycle from cycle 1, with the correct owner and data.
REQ-043 Reset mid-load: resetn low in the cycle after d_gnt -> d_rvalid stays 0, conflict_cnt=0, FSM IDLE after release.
REQ-044 Wrap: conflict_cnt forced to 0xFFFFFFFF, then one collision cycle -> conflict_cnt=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the response-owner encoding and default parameter values.
package mem_arbiter_pkg;

  localparam int ADDR_BITS_DEFAULT  = 14;
  localparam int STARVE_MAX_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } resp_state_e;

endpackage

// File: rtl/mem_arbiter_prio.sv
// Combinational grant priority: data normally wins a collision,
// but a fetch that has lost STARVE_MAX cycles in a row is forced through.
module arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          enable,
  input  logic          i_req,
  input  logic          d_req,
  input  logic [SW-1:0] starve_cnt,
  output logic          i_gnt,
  output logic          d_gnt
);

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (enable) begin
      if (i_req && d_req) begin
        if (starve_cnt == SW'(STARVE_MAX)) i_gnt = 1'b1;
        else                               d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-ported RAM with
// one access per cycle and a fixed one-cycle read latency.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS  = ADDR_BITS_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_req,
  input  logic [31:0]          i_addr,
  output logic                 i_gnt,
  output logic                 i_rvalid,
  output logic [31:0]          i_rdata,
  input  logic                 d_req,
  input  logic [31:0]          d_addr,
  input  logic [3:0]           d_wmask,
  input  logic [31:0]          d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [31:0]          d_rdata,
  output logic                 ram_en,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [3:0]           ram_wmask,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata,
  output logic [31:0]          conflict_cnt
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  resp_state_e   state_q, state_d;
  logic          unused_addr_bits;

  // Grants are gated by resetn so requests are ignored while in reset.
  arb_prio #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_prio (
    .enable     (resetn),
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt),
    .i_gnt      (i_gnt),
    .d_gnt      (d_gnt)
  );

  assign unused_addr_bits = ^{i_addr, d_addr};

  always_comb begin
    ram_en    = i_gnt | d_gnt;
    ram_addr  = d_gnt ? d_addr[ADDR_BITS+1:2] : i_addr[ADDR_BITS+1:2];
    ram_wmask = d_gnt ? d_wmask : 4'b0000;
    ram_wdata = d_gnt ? d_wdata : 32'd0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (i_req && !i_gnt) begin
      if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             conflict_cnt <= 32'd0;
    else if (i_req && d_req) conflict_cnt <= conflict_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // The state names whose read returns next cycle; stores never own a response.
  always_comb begin
    state_d = IDLE;
    if (i_gnt)                          state_d = RESP_I;
    else if (d_gnt && d_wmask == 4'b0)  state_d = RESP_D;

    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = 32'd0;
    d_rdata  = 32'd0;
    unique case (state_q)
      RESP_I: begin
        i_rvalid = 1'b1;
        i_rdata  = ram_rdata;
      end
      RESP_D: begin
        d_rvalid = 1'b1;
        d_rdata  = ram_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a RAM model on the ram_* side and a
// behavioural reference model of grants, responses and counters.
module tb_mem_arbiter;

  localparam int ADDR_BITS  = 14;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wmask;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, ram_en;
  logic [31:0] i_rdata, d_rdata, ram_wdata, conflict_cnt;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [3:0]  ram_wmask;
  logic [31:0] ram_rdata = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] ram_mem [int];
  logic [31:0] shadow  [int];
  int          m_starve;
  logic [31:0] m_conflict;
  int          m_owner;
  logic [31:0] m_data;
  logic        exp_i_gnt, exp_d_gnt, exp_i_rvalid, exp_d_rvalid;
  logic [31:0] exp_i_rdata, exp_d_rdata;

  mem_arbiter #(.ADDR_BITS(ADDR_BITS), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wmask(ram_wmask),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int a);
    return {a[15:0], ~a[15:0]} ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] data, logic [3:0] mask);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ram_rd(int a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] sh_rd(int a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  function automatic int wa(logic [31:0] byte_addr);
    return int'(byte_addr[ADDR_BITS+1:2]);
  endfunction

  // RAM: one-cycle read latency, byte-masked writes
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wmask == 4'b0) ram_rdata <= ram_rd(int'(ram_addr));
      else ram_mem[int'(ram_addr)] = merge(ram_rd(int'(ram_addr)), ram_wdata, ram_wmask);
    end
  end

  // Expected outputs for the current cycle, sampled 1 time unit after inputs change
  task automatic eval_model();
    #1;
    if (!resetn) begin
      m_starve = 0; m_conflict = 32'd0; m_owner = 0;
    end
    exp_i_gnt = 1'b0;
    exp_d_gnt = 1'b0;
    if (resetn) begin
      if (i_req && (!d_req || m_starve >= STARVE_MAX)) exp_i_gnt = 1'b1;
      else if (d_req)                                   exp_d_gnt = 1'b1;
    end
    exp_i_rvalid = (m_owner == 1);
    exp_d_rvalid = (m_owner == 2);
    exp_i_rdata  = exp_i_rvalid ? m_data : 32'd0;
    exp_d_rdata  = exp_d_rvalid ? m_data : 32'd0;
  endtask

  task automatic advance();
    @(posedge clk);
    if (resetn) begin
      if (i_req && d_req) m_conflict = m_conflict + 32'd1;
      m_owner = 0;
      if (exp_i_gnt) begin
        m_owner = 1;
        m_data  = sh_rd(wa(i_addr));
      end else if (exp_d_gnt) begin
        if (d_wmask == 4'b0) begin
          m_owner = 2;
          m_data  = sh_rd(wa(d_addr));
        end else begin
          shadow[wa(d_addr)] = merge(sh_rd(wa(d_addr)), d_wdata, d_wmask);
        end
      end
      if (i_req && !exp_i_gnt) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else                     m_starve = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; d_req = 1'b0; d_wmask = 4'b0;
    i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    i_req = 1'b1; d_req = 1'b1; i_addr = $urandom; d_addr = $urandom;
    d_wmask = 4'hF; d_wdata = $urandom;
    for (int k = 0; k < 2; k++) begin
      eval_model();
      n_checks++; if ({i_gnt, d_gnt, ram_en} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b want 000", {i_gnt, d_gnt, ram_en}); end
      n_checks++; if (ram_wmask !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_wmask: got %h want 0", ram_wmask); end
      n_checks++; if ({i_rvalid, d_rvalid} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_rvalid: got %b want 00", {i_rvalid, d_rvalid}); end
      n_checks++; if (conflict_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_conflict: got %h want 0", conflict_cnt); end
      advance();
    end
    idle_inputs();
    resetn = 1'b1;
    eval_model();
    advance();
  endtask

  task automatic test_fetch_only();
    d_req = 1'b1; d_addr = 32'h10; d_wmask = 4'hF; d_wdata = 32'h0000_0013;
    eval_model();
    n_checks++; if ({d_gnt, ram_wmask, ram_addr} !== {1'b1, 4'hF, 14'd4}) begin n_fail++; $display("[TB] FAIL fetch_setup_store: got gnt=%b mask=%h addr=%h want 1 f 4", d_gnt, ram_wmask, ram_addr); end
    advance();
    idle_inputs();
    i_req = 1'b1; i_addr = 32'h10;
    eval_model();
    n_checks++; if ({i_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("[TB] FAIL fetch_gnt: got %b want 10", {i_gnt, d_gnt}); end
    n_checks++; if ({ram_en, ram_addr, ram_wmask} !== {1'b1, 14'd4, 4'h0}) begin n_fail++; $display("[TB] FAIL fetch_ram: got en=%b addr=%h mask=%h want 1 4 0", ram_en, ram_addr, ram_wmask); end
    n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL store_no_rvalid: got %b want 0", d_rvalid); end
    advance();
    idle_inputs();
    eval_model();
    n_checks++; if ({i_rvalid, d_rvalid} !== 2'b10) begin n_fail++; $display("[TB] FAIL fetch_rvalid: got %b want 10", {i_rvalid, d_rvalid}); end
    n_checks++; if (i_rdata !== 32'h0000_0013) begin n_fail++; $display("[TB] FAIL fetch_rdata: got %h want 00000013", i_rdata); end
    advance();
  endtask

  task automatic test_collision();
    logic want_i;
    resetn = 1'b0; idle_inputs();
    eval_model(); advance();
    resetn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_req = 1'b1; i_addr = 32'($urandom_range(255)) << 2;
      d_req = 1'b1; d_addr = 32'h20; d_wmask = 4'b0;
      eval_model();
      want_i = (k % 4 == 3);
      n_checks++; if ({i_gnt, d_gnt} !== {want_i, !want_i}) begin n_fail++; $display("[TB] FAIL collide_gnt cyc %0d: got %b want %b", k, {i_gnt, d_gnt}, {want_i, !want_i}); end
      n_checks++; if ({i_rvalid, d_rvalid, i_rdata, d_rdata} !== {exp_i_rvalid, exp_d_rvalid, exp_i_rdata, exp_d_rdata}) begin n_fail++; $display("[TB] FAIL collide_resp cyc %0d: got %b%b %h %h want %b%b %h %h", k, i_rvalid, d_rvalid, i_rdata, d_rdata, exp_i_rvalid, exp_d_rvalid, exp_i_rdata, exp_d_rdata); end
      advance();
    end
    idle_inputs();
    eval_model();
    n_checks++; if (conflict_cnt !== 32'd8) begin n_fail++; $display("[TB] FAIL collide_count: got %0d want 8", conflict_cnt); end
    n_checks++; if ({i_rvalid, i_rdata} !== {1'b1, exp_i_rdata}) begin n_fail++; $display("[TB] FAIL collide_last_fetch: got %b %h want 1 %h", i_rvalid, i_rdata, exp_i_rdata); end
    advance();
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_addr = 32'h40; d_wmask = 4'hF; d_wdata = 32'h1122_3344;
    eval_model(); advance();
    d_wmask = 4'b0010; d_wdata = 32'h0000_AB00;
    eval_model();
    n_checks++; if ({d_gnt, ram_wmask, ram_wdata} !== {1'b1, 4'b0010, 32'h0000_AB00}) begin n_fail++; $display("[TB] FAIL store_ram: got gnt=%b mask=%b data=%h want 1 0010 0000ab00", d_gnt, ram_wmask, ram_wdata); end
    advance();
    d_wmask = 4'b0;
    eval_model();
    n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL store_rvalid: got %b want 0", d_rvalid); end
    advance();
    idle_inputs();
    eval_model();
    n_checks++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h1122_AB44}) begin n_fail++; $display("[TB] FAIL load_after_store: got %b %h want 1 1122ab44", d_rvalid, d_rdata); end
    advance();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 9; k++) begin
      idle_inputs();
      if (k < 8) begin
        if (k % 2 == 0) begin i_req = 1'b1; i_addr = 32'($urandom_range(127)) << 2; end
        else            begin d_req = 1'b1; d_addr = 32'($urandom_range(127)) << 2; end
      end
      eval_model();
      if (k >= 1) begin
        n_checks++; if ({i_rvalid, d_rvalid} !== {k % 2 == 1, k % 2 == 0}) begin n_fail++; $display("[TB] FAIL b2b_owner cyc %0d: got %b%b", k, i_rvalid, d_rvalid); end
        n_checks++; if ((i_rdata | d_rdata) !== (exp_i_rdata | exp_d_rdata)) begin n_fail++; $display("[TB] FAIL b2b_data cyc %0d: got %h want %h", k, i_rdata | d_rdata, exp_i_rdata | exp_d_rdata); end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_load();
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h80; d_wmask = 4'b0;
    eval_model();
    n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_dgnt: got %b want 1", d_gnt); end
    advance();
    resetn = 1'b0; idle_inputs();
    eval_model();
    n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_rvalid_in_reset: got %b want 0", d_rvalid); end
    advance();
    resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      eval_model();
      n_checks++; if ({i_rvalid, d_rvalid, conflict_cnt} !== {2'b00, 32'd0}) begin n_fail++; $display("[TB] FAIL midrst_after cyc %0d: got %b%b %h want 00 0", k, i_rvalid, d_rvalid, conflict_cnt); end
      advance();
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    force dut.conflict_cnt = 32'hFFFF_FFFF;
    #1 release dut.conflict_cnt;
    m_conflict = 32'hFFFF_FFFF;
    eval_model();
    n_checks++; if (conflict_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL wrap_preload: got %h want ffffffff", conflict_cnt); end
    i_req = 1'b1; d_req = 1'b1;
    eval_model(); advance();
    idle_inputs();
    eval_model();
    n_checks++; if (conflict_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL wrap: got %h want 0", conflict_cnt); end
    advance();
  endtask

  task automatic test_random();
    idle_inputs();
    exp_i_gnt = 1'b0; exp_d_gnt = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!i_req || exp_i_gnt || $urandom_range(7) == 0) begin
        i_req  = 1'($urandom_range(1));
        i_addr = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(63)) << 2);
      end
      if (!d_req || exp_d_gnt || $urandom_range(7) == 0) begin
        d_req   = 1'($urandom_range(1));
        d_addr  = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(63)) << 2);
        d_wmask = $urandom_range(1) ? 4'($urandom) : 4'b0;
        d_wdata = $urandom;
      end
      eval_model();
      n_checks++; if ({i_gnt, d_gnt, ram_en} !== {exp_i_gnt, exp_d_gnt, exp_i_gnt | exp_d_gnt}) begin n_fail++; $display("[TB] FAIL rnd_gnt cyc %0d: got %b%b%b want %b%b", c, i_gnt, d_gnt, ram_en, exp_i_gnt, exp_d_gnt); end
      if (exp_i_gnt || exp_d_gnt) begin
        n_checks++; if (int'(ram_addr) !== (exp_i_gnt ? wa(i_addr) : wa(d_addr))) begin n_fail++; $display("[TB] FAIL rnd_addr cyc %0d: got %h want %h", c, ram_addr, exp_i_gnt ? wa(i_addr) : wa(d_addr)); end
      end
      n_checks++; if (ram_wmask !== (exp_d_gnt ? d_wmask : 4'b0)) begin n_fail++; $display("[TB] FAIL rnd_wmask cyc %0d: got %h want %h", c, ram_wmask, exp_d_gnt ? d_wmask : 4'b0); end
      if (exp_d_gnt && d_wmask != 4'b0) begin
        n_checks++; if (ram_wdata !== d_wdata) begin n_fail++; $display("[TB] FAIL rnd_wdata cyc %0d: got %h want %h", c, ram_wdata, d_wdata); end
      end
      n_checks++; if ({i_rvalid, i_rdata} !== {exp_i_rvalid, exp_i_rdata}) begin n_fail++; $display("[TB] FAIL rnd_iresp cyc %0d: got %b %h want %b %h", c, i_rvalid, i_rdata, exp_i_rvalid, exp_i_rdata); end
      n_checks++; if ({d_rvalid, d_rdata} !== {exp_d_rvalid, exp_d_rdata}) begin n_fail++; $display("[TB] FAIL rnd_dresp cyc %0d: got %b %h want %b %h", c, d_rvalid, d_rdata, exp_d_rvalid, exp_d_rdata); end
      n_checks++; if (conflict_cnt !== m_conflict) begin n_fail++; $display("[TB] FAIL rnd_conflict cyc %0d: got %h want %h", c, conflict_cnt, m_conflict); end
      advance();
    end
  endtask

  initial begin
    m_starve = 0; m_conflict = 32'd0; m_owner = 0; m_data = 32'd0;
    test_reset();
    test_fetch_only();
    test_collision();
    test_store_load();
    test_back_to_back();
    test_reset_mid_load();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
